// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full-adder slice over WIDTH cycles.
// Latency: accept edge + WIDTH RUN edges; done pulses for one cycle, then IDLE (WIDTH+2 per op).
// Optional SERIAL_ADD_SUB_EN: sub=1 on accept computes a - b; otherwise sub is ignored.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s, fa_c;

`ifndef SERIAL_ADD_SUB_EN
   logic unused_sub;
   assign unused_sub = sub;
`endif

   // Full-adder slice on the current LSBs and the held carry
   always_comb begin
      fa_s = a_q[0] ^ b_q[0] ^ carry_q;
      fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
   end

   // Next-state and datapath updates; every register holds unless its state acts on it
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
`ifdef SERIAL_ADD_SUB_EN
               // Two's-complement subtract: invert B and force the carry-in to one
               if (sub) begin
                  b_d     = ~b;
                  carry_d = 1'b1;
               end
`endif
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            if (cnt_q == LAST) begin
               // carry_q here is the carry into the MSB, so ovf is its XOR with the final carry
               sum_d   = res_d;
               cout_d  = fa_c;
               ovf_d   = carry_q ^ fa_c;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers; async reset clears everything, aborting any operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed vectors plus randomized operations
// checked against an arithmetic reference model (a + b + cin, or a - b when enabled).
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cyc = 0;

   logic [WIDTH-1:0] exp_sum;
   logic             exp_cout;
   logic             exp_ovf;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and done-pulse counter, sampled just after each rising edge
   always @(posedge clk) begin
      cyc++;
      #1;
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: returns {ovf, cout, sum} from plain integer arithmetic
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                                             input logic ocin, input logic osub);
      logic [WIDTH-1:0] bb;
      logic             c;
      logic [WIDTH:0]   full;
      logic             v;
      bb = ob;
      c  = ocin;
`ifdef SERIAL_ADD_SUB_EN
      if (osub) begin
         bb = ~ob;
         c  = 1'b1;
      end
`else
      if (osub) c = ocin;
`endif
      full = {1'b0, oa} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
      v = (oa[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != oa[WIDTH-1]);
      return {v, full[WIDTH], full[WIDTH-1:0]};
   endfunction

   // One operation from IDLE; with noise, random start pulses and operand changes hit RUN and DONE
   task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic ocin, input logic osub, input logic noise);
      logic [WIDTH+1:0] exp_r;
      int lat;
      exp_r = model(oa, ob, ocin, osub);
      @(negedge clk);
      start = 1'b1; a = oa; b = ob; cin = ocin; sub = osub;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < WIDTH + 4) begin
         chk("busy_run", busy, 1);
         chk("sum_hold", sum, exp_sum);
         if (noise) begin
            start = 1'($urandom % 2);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom % 2);
            sub = 1'($urandom % 2);
         end
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, WIDTH);
      chk("done", done, 1);
      chk("busy_at_done", busy, 0);
      chk("sum", sum, exp_r[WIDTH-1:0]);
      chk("cout", cout, exp_r[WIDTH]);
      chk("ovf", ovf, exp_r[WIDTH+1]);
      exp_sum  = exp_r[WIDTH-1:0];
      exp_cout = exp_r[WIDTH];
      exp_ovf  = exp_r[WIDTH+1];
      start = noise ? 1'($urandom % 2) : 1'b0;
      a = WIDTH'($urandom);
      @(negedge clk);
      start = 1'b0;
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
      chk("sum_keep", sum, exp_sum);
      chk("cout_keep", cout, exp_cout);
      chk("ovf_keep", ovf, exp_ovf);
   endtask

   initial begin
      int d0;
      int q[$];
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      do_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      do_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
      do_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);

      // Start during RUN is ignored; exactly one done follows
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 8'hF0;
      @(negedge clk);
      start = 1'b0;
      repeat (WIDTH + 4) @(negedge clk);
      chk("ign_done_count", done_cnt - d0, 1);
      chk("ign_sum", sum, 8'h02);
      chk("ign_busy", busy, 0);
      exp_sum = 8'h02; exp_cout = 1'b0; exp_ovf = 1'b0;

      // Async reset mid-RUN aborts without a done
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h10;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_ovf", ovf, 0);
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (WIDTH + 4) @(negedge clk);
      chk("rst_no_done", done_cnt - d0, 0);
      exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      do_op(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);

      // Randomized operations, half of them with noise on the inputs during RUN/DONE
      for (int i = 0; i < 40; i++) begin
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom % 2), 1'($urandom % 2),
               1'($urandom % 2));
      end

      // Back-to-back with start held high
      @(negedge clk);
      start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0; sub = 1'b0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) begin
            q.push_back(cyc);
            chk("b2b_sum", sum, 8'h07);
         end
      end
      start = 1'b0;
      chk("b2b_count_ok", (q.size() >= 4) ? 1 : 0, 1);
      for (int i = 1; i < q.size(); i++) chk("b2b_period", q[i] - q[i-1], WIDTH + 2);
      repeat (WIDTH + 4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
